// File: rtl/dadda_mult_arbiter_if.sv
// Request/response bundle for the shared truncated-multiplier arbiter.
// DADDA_ARB_ERRMON_EN adds the rsp_err / err_max monitor signals.
interface dadda_mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic                      en;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][7:0]      req_a;
  logic [NREQ-1:0][7:0]      req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [15:0]               rsp_p;
  logic [IDW-1:0]            rsp_id;
  logic                      busy;
`ifdef DADDA_ARB_ERRMON_EN
  logic [15:0]               rsp_err;
  logic [15:0]               err_max;

  modport slave  (input  en, req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_p, rsp_id, busy, rsp_err, err_max);
  modport master (output en, req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_p, rsp_id, busy, rsp_err, err_max);
`else
  modport slave  (input  en, req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_p, rsp_id, busy);
  modport master (output en, req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_p, rsp_id, busy);
`endif
endinterface

// File: rtl/dadda_mult_arbiter.sv
// Round-robin sharing of one 8x8 truncated multiplier across NREQ clients, with a tagged response FIFO.
// Define DADDA_ARB_ERRMON_EN to carry the exact product and expose rsp_err / err_max.

// Truncated 8x8 product: partial products a0b0, a1b0, a0b1 are never generated.
module dadda_8b_trunc_2 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i + j >= 2) p = p + (16'(a[i] & b[j]) << (i + j));
      end
    end
  end
endmodule

module dadda_mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int RSP_DEPTH = 4,
  parameter int IDW       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  dadda_mult_arbiter_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int AW     = $clog2(RSP_DEPTH);
  localparam int CW     = AW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [15:0]    p;
    logic [IDW-1:0] id;
`ifdef DADDA_ARB_ERRMON_EN
    logic [15:0]    x;
`endif
  } rsp_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [STAGES:1] vld_pipe;

  logic [7:0]      s1_a, s1_b;
  logic [IDW-1:0]  s1_id;
  logic [15:0]     prod;
  rsp_t            s2;

  rsp_t            mem [RSP_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  rsp_t            head;
  logic            fifo_wr, fifo_rd;

  logic            found;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  jj;
  logic [CW-1:0]   used;
  logic            credit_ok, grant;

  // Rotating search starting at ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    jj    = '0;
    for (int k = 0; k < NREQ; k++) begin
      jj = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req_valid[jj]) begin
        found = 1'b1;
        gidx  = jj;
      end
    end
  end

  // Registered occupancy only: a pop this cycle frees its slot next cycle.
  assign used      = CW'(count) + CW'(vld_pipe[1]) + CW'(vld_pipe[2]);
  assign credit_ok = used < CW'(RSP_DEPTH);
  assign grant     = (state == RUN) && bus.en && credit_ok && found;
  assign bus.req_ready = grant ? (NREQ'(1) << gidx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (grant) ptr <= IDW'((int'(gidx) + 1) % NREQ);
  end

  // Pipeline: S1 holds operands, multiplier sits between S1 and S2.
  dadda_8b_trunc_2 u_mul (.a(s1_a), .b(s1_b), .p(prod));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], grant};
      if (grant) begin
        s1_a  <= bus.req_a[gidx];
        s1_b  <= bus.req_b[gidx];
        s1_id <= gidx;
      end
      if (vld_pipe[1]) begin
        s2.p  <= prod;
        s2.id <= s1_id;
`ifdef DADDA_ARB_ERRMON_EN
        s2.x  <= 16'(s1_a) * 16'(s1_b);
`endif
      end
    end
  end

  // Response FIFO; credit guarantees a free slot whenever S2 writes.
  assign fifo_wr       = vld_pipe[STAGES];
  assign bus.rsp_valid = (count != '0);
  assign fifo_rd       = bus.rsp_valid && bus.rsp_ready;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
    end
  end

  assign bus.rsp_p  = bus.rsp_valid ? head.p  : '0;
  assign bus.rsp_id = bus.rsp_valid ? head.id : '0;
  assign bus.busy   = (|vld_pipe) || bus.rsp_valid;

`ifdef DADDA_ARB_ERRMON_EN
  assign bus.rsp_err = bus.rsp_valid ? (head.x - head.p) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err_max <= '0;
    else if (fifo_rd && (bus.rsp_err > bus.err_max)) bus.err_max <= bus.rsp_err;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Entering RUN costs one cycle with no grant; DRAIN waits for every in-flight op.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en && (|bus.req_valid)) state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = DRAIN;
      DRAIN:   if (bus.en) state_nxt = RUN;
               else if (!bus.busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule
